// File: rtl/vending_pkg.sv
// Shared types and constants for the vending-machine sale controller.
package vending_pkg;

    localparam int AMT_W = 12;

    localparam logic [AMT_W-1:0] COIN_A = 12'd100;
    localparam logic [AMT_W-1:0] COIN_B = 12'd500;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        CHANGE = 2'd2
    } state_t;

endpackage

// File: rtl/vending_change_fsm_hold_timer.sv
// Loadable down-counter: done is high on the last of HOLD_CYCLES cycles after start.
module hold_timer #(
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic          run_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            cnt_q <= LOAD;
            run_q <= 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign done = run_q && (cnt_q == '0);

endmodule

// File: rtl/vending_change_fsm.sv
// Coin accumulation, purchase validation and change presentation for the vending machine.
module vending_change_fsm
    import vending_pkg::*;
#(
    parameter int PRICE0      = 300,
    parameter int PRICE1      = 500,
    parameter int PRICE2      = 800,
    parameter int PRICE3      = 1200,
    parameter int MAX_CREDIT  = 1500,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             coin100,
    input  logic             coin500,
    input  logic [1:0]       sel,
    input  logic             buy,
    input  logic             cancel,
    output logic [AMT_W-1:0] credit,
    output logic [AMT_W-1:0] vuelto,
    output logic             vuelto_en,
    output logic             dispense,
    output logic             coin_reject,
    output logic             insufficient
);

    localparam logic [AMT_W-1:0] P0    = AMT_W'(PRICE0);
    localparam logic [AMT_W-1:0] P1    = AMT_W'(PRICE1);
    localparam logic [AMT_W-1:0] P2    = AMT_W'(PRICE2);
    localparam logic [AMT_W-1:0] P3    = AMT_W'(PRICE3);
    localparam logic [AMT_W:0]   LIMIT = (AMT_W+1)'(MAX_CREDIT);

    state_t           state_q;
    logic [AMT_W-1:0] credit_q;
    logic [AMT_W-1:0] vuelto_q;
    logic             vuelto_en_q;
    logic             dispense_q;
    logic             coin_reject_q;
    logic             insufficient_q;

    logic [AMT_W-1:0] price_d;
    logic [AMT_W-1:0] coin_val_d;
    logic [AMT_W:0]   credit_sum_d;
    logic             coin_any_d;
    logic             coin_bad_d;
    logic             cancel_ok_d;
    logic             buy_ok_d;
    logic             buy_fail_d;
    logic             start_d;
    logic             hold_done;

    always_comb begin
        unique case (sel)
            2'd0:    price_d = P0;
            2'd1:    price_d = P1;
            2'd2:    price_d = P2;
            default: price_d = P3;
        endcase
        coin_any_d   = coin100 | coin500;
        coin_val_d   = coin500 ? COIN_B : COIN_A;
        credit_sum_d = {1'b0, credit_q} + {1'b0, coin_val_d};
        // Two coins at once cannot be told apart reliably, so both go back.
        coin_bad_d   = (coin100 & coin500) | (credit_sum_d > LIMIT);
        cancel_ok_d  = cancel && (state_q == ACCUM);
        buy_ok_d     = !cancel_ok_d && buy && (state_q != CHANGE) && (credit_q >= price_d);
        buy_fail_d   = !cancel_ok_d && buy && (state_q != CHANGE) && (credit_q < price_d);
        start_d      = cancel_ok_d | buy_ok_d;
    end

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold (
        .clk  (clk),
        .rst  (rst),
        .start(start_d),
        .done (hold_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            vuelto_q       <= '0;
            vuelto_en_q    <= 1'b0;
            dispense_q     <= 1'b0;
            coin_reject_q  <= 1'b0;
            insufficient_q <= 1'b0;
        end else begin
            dispense_q     <= 1'b0;
            coin_reject_q  <= 1'b0;
            insufficient_q <= 1'b0;
            unique case (state_q)
                IDLE, ACCUM: begin
                    if (cancel_ok_d) begin
                        vuelto_q      <= credit_q;
                        vuelto_en_q   <= 1'b1;
                        credit_q      <= '0;
                        coin_reject_q <= coin_any_d;
                        state_q       <= CHANGE;
                    end else if (buy_ok_d) begin
                        dispense_q    <= 1'b1;
                        vuelto_q      <= credit_q - price_d;
                        vuelto_en_q   <= 1'b1;
                        credit_q      <= '0;
                        coin_reject_q <= coin_any_d;
                        state_q       <= CHANGE;
                    end else begin
                        insufficient_q <= buy_fail_d;
                        if (coin_any_d) begin
                            if (coin_bad_d) begin
                                coin_reject_q <= 1'b1;
                            end else begin
                                credit_q <= credit_sum_d[AMT_W-1:0];
                                state_q  <= ACCUM;
                            end
                        end
                    end
                end
                CHANGE: begin
                    coin_reject_q <= coin_any_d;
                    if (hold_done) begin
                        vuelto_q    <= '0;
                        vuelto_en_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign credit       = credit_q;
    assign vuelto       = vuelto_q;
    assign vuelto_en    = vuelto_en_q;
    assign dispense     = dispense_q;
    assign coin_reject  = coin_reject_q;
    assign insufficient = insufficient_q;

endmodule

// File: tb/tb_vending_change_fsm.sv
// Bench for vending_change_fsm: directed sale scenarios plus random pulses against a behavioural model.
module tb_vending_change_fsm;

    localparam int HOLD = 8;

    logic        clk;
    logic        rst;
    logic        coin100;
    logic        coin500;
    logic [1:0]  sel;
    logic        buy;
    logic        cancel;
    logic [11:0] credit;
    logic [11:0] vuelto;
    logic        vuelto_en;
    logic        dispense;
    logic        coin_reject;
    logic        insufficient;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: plain amounts plus a count of display cycles left.
    int prices[4] = '{300, 500, 800, 1200};
    int m_credit, m_vuelto, m_hold;
    int m_en, m_disp, m_rej, m_ins;

    vending_change_fsm #(
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .coin100     (coin100),
        .coin500     (coin500),
        .sel         (sel),
        .buy         (buy),
        .cancel      (cancel),
        .credit      (credit),
        .vuelto      (vuelto),
        .vuelto_en   (vuelto_en),
        .dispense    (dispense),
        .coin_reject (coin_reject),
        .insufficient(insufficient)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_credit = 0; m_vuelto = 0; m_hold = 0;
        m_en = 0; m_disp = 0; m_rej = 0; m_ins = 0;
    endtask

    task automatic model_step(input bit c1, input bit c5, input bit b, input bit cn,
                              input int s);
        int v;
        m_disp = 0; m_rej = 0; m_ins = 0;
        if (m_hold > 0) begin
            m_rej = (c1 || c5) ? 1 : 0;
            m_hold--;
            if (m_hold == 0) begin
                m_en = 0;
                m_vuelto = 0;
            end
        end else if (cn && m_credit > 0) begin
            m_vuelto = m_credit; m_en = 1; m_credit = 0; m_hold = HOLD;
            m_rej = (c1 || c5) ? 1 : 0;
        end else if (b && m_credit >= prices[s]) begin
            m_disp = 1; m_vuelto = m_credit - prices[s]; m_en = 1;
            m_credit = 0; m_hold = HOLD;
            m_rej = (c1 || c5) ? 1 : 0;
        end else begin
            m_ins = b ? 1 : 0;
            if (c1 && c5) begin
                m_rej = 1;
            end else if (c1 || c5) begin
                v = c5 ? 500 : 100;
                if (m_credit + v > 1500) m_rej = 1;
                else m_credit += v;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("credit", int'(credit), m_credit);
        check_eq("vuelto", int'(vuelto), m_vuelto);
        check_eq("vuelto_en", int'(vuelto_en), m_en);
        check_eq("dispense", int'(dispense), m_disp);
        check_eq("coin_reject", int'(coin_reject), m_rej);
        check_eq("insufficient", int'(insufficient), m_ins);
    endtask

    task automatic step(input bit c1, input bit c5, input bit b, input bit cn,
                        input int s);
        coin100 = c1; coin500 = c5; buy = b; cancel = cn; sel = 2'(s);
        @(posedge clk);
        model_step(c1, c5, b, cn, s);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic async_reset(input string tag);
        coin100 = 0; coin500 = 0; buy = 0; cancel = 0; sel = 2'd0;
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        check_eq({tag, "_credit"}, int'(credit), 0);
        check_eq({tag, "_vuelto"}, int'(vuelto), 0);
        check_eq({tag, "_vuelto_en"}, int'(vuelto_en), 0);
        check_eq({tag, "_dispense"}, int'(dispense), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
    endtask

    initial begin
        int en_cycles;
        int n_disp;
        rst = 1'b0; coin100 = 0; coin500 = 0; sel = 2'd0; buy = 0; cancel = 0;
        model_clear();
        #1 rst = 1'b1;
        #20;
        check_outputs();
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // Sale of product 2 with 300 change, display held for HOLD cycles.
        step(0, 1, 0, 0, 0); check_eq("s1_credit500", int'(credit), 500);
        step(0, 1, 0, 0, 0); check_eq("s1_credit1000", int'(credit), 1000);
        step(1, 0, 0, 0, 0); check_eq("s1_credit1100", int'(credit), 1100);
        step(0, 0, 1, 0, 2);
        check_eq("s1_dispense", int'(dispense), 1);
        check_eq("s1_vuelto", int'(vuelto), 300);
        en_cycles = 1;
        n_disp = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0, 0);
            if (dispense) n_disp++;
            if (vuelto_en) en_cycles++;
        end
        check_eq("s1_en_cycles", en_cycles, HOLD);
        check_eq("s1_single_dispense", n_disp, 0);

        // Credit limit, then cancel returns everything.
        step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
        check_eq("s2_credit1500", int'(credit), 1500);
        step(1, 0, 0, 0, 0);
        check_eq("s2_reject", int'(coin_reject), 1);
        check_eq("s2_credit_kept", int'(credit), 1500);
        step(0, 0, 0, 1, 0);
        check_eq("s2_vuelto", int'(vuelto), 1500);
        check_eq("s2_no_dispense", int'(dispense), 0);
        idle(HOLD + 1);

        // Insufficient credit and simultaneous coins.
        step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 1);
        check_eq("s3_insufficient", int'(insufficient), 1);
        check_eq("s3_credit200", int'(credit), 200);
        step(1, 1, 0, 0, 0);
        check_eq("s3_both_reject", int'(coin_reject), 1);
        check_eq("s3_credit_still200", int'(credit), 200);
        step(0, 0, 0, 1, 0);
        idle(HOLD + 1);

        // Exact-price sale with a coin in the same cycle, coin during CHANGE.
        step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        check_eq("s4_dispense", int'(dispense), 1);
        check_eq("s4_vuelto0", int'(vuelto), 0);
        check_eq("s4_en", int'(vuelto_en), 1);
        check_eq("s4_reject", int'(coin_reject), 1);
        step(0, 1, 0, 0, 0);
        check_eq("s4_change_reject", int'(coin_reject), 1);
        check_eq("s4_credit0", int'(credit), 0);
        idle(HOLD + 1);

        // Cancel beats buy in the same cycle.
        step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 3);
        check_eq("s5_vuelto1200", int'(vuelto), 1200);
        check_eq("s5_no_dispense", int'(dispense), 0);
        idle(HOLD + 1);

        // Asynchronous reset in ACCUM and in CHANGE.
        step(0, 1, 0, 0, 0);
        async_reset("rst_accum");
        step(0, 1, 0, 0, 0); step(0, 0, 0, 1, 0); idle(2);
        async_reset("rst_change");

        // Random pulses against the model.
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 6) == 0, $urandom_range(0, 24) == 0,
                 int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
